// File: rtl/key_loader_if.sv
// Serial key-load bus between a key source and key_loader. It carries the bit
// stream, an abort strobe, the committed key bits and the status flags.
interface key_loader_if;
  logic sdi;
  logic sdi_valid;
  logic sdi_ready;
  logic abort;
  logic p1, p2, p3, p4;
  logic x_1, x_2;
  logic key_loaded;
  logic done;
  logic err;
  logic locked;

  modport master (
    output sdi, sdi_valid, abort,
    input  sdi_ready, p1, p2, p3, p4, x_1, x_2, key_loaded, done, err, locked
  );

  modport slave (
    input  sdi, sdi_valid, abort,
    output sdi_ready, p1, p2, p3, p4, x_1, x_2, key_loaded, done, err, locked
  );
endinterface

// File: rtl/key_loader.sv
// Serial key loader: shifts in an even-parity protected key frame, commits it
// to the locked core's key inputs, and locks up after MAX_FAIL bad frames.
module key_loader #(
  parameter int KEY_W    = 6,
  parameter int MAX_FAIL = 3
) (
  input logic         clk,
  input logic         rst_n,
  key_loader_if.slave bus
);

  localparam int CNT_W  = $clog2(KEY_W + 2);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, COMMIT, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [KEY_W:0]      shadow_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [FAIL_W-1:0]   fail_q;
  logic [KEY_W-1:0]    key_q;
  logic [KEY_W-1:0]    key_vis;
  logic                loaded_q, done_q, err_q, active_q;
  logic                in_rx, xfer, kill, last_bit, parity_ok, last_fail;

  // The shadow holds key bits plus the parity bit, so an even frame XORs to 0.
  assign in_rx     = (state_q == IDLE) || (state_q == SHIFT);
  assign kill      = in_rx && bus.abort;
  assign xfer      = in_rx && active_q && bus.sdi_valid && !bus.abort;
  assign last_bit  = (cnt_q == CNT_W'(KEY_W));
  assign parity_ok = ~^shadow_q;
  assign last_fail = (fail_q == FAIL_W'(MAX_FAIL - 1));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, SHIFT: begin
        if (kill)      state_d = IDLE;
        else if (xfer) state_d = last_bit ? CHECK : SHIFT;
      end
      CHECK:   state_d = parity_ok ? COMMIT : (last_fail ? LOCKED : IDLE);
      COMMIT:  state_d = IDLE;
      LOCKED:  state_d = LOCKED;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register here has an async reset; the design holds no RAM, so
  // a partial frame can never survive rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      key_q    <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      if (kill) begin
        shadow_q <= '0;
        cnt_q    <= '0;
      end else if (xfer) begin
        shadow_q[cnt_q] <= bus.sdi;
        cnt_q           <= cnt_q + CNT_W'(1);
      end
      if (state_q == CHECK) begin
        cnt_q <= '0;
        if (!parity_ok) begin
          err_q    <= 1'b1;
          shadow_q <= '0;
          if (fail_q != FAIL_W'(MAX_FAIL)) fail_q <= fail_q + FAIL_W'(1);
        end
      end
      if (state_q == COMMIT) begin
        key_q    <= shadow_q[KEY_W-1:0];
        loaded_q <= 1'b1;
        done_q   <= 1'b1;
        fail_q   <= '0;
        shadow_q <= '0;
      end
    end
  end

  // The lock state masks the key so the core sees all zeros while locked.
  always_comb begin
    key_vis        = (state_q == LOCKED) ? '0 : key_q;
    bus.sdi_ready  = active_q && in_rx;
    bus.locked     = (state_q == LOCKED);
    bus.key_loaded = loaded_q && (state_q != LOCKED);
    bus.done       = done_q;
    bus.err        = err_q;
    bus.p1         = key_vis[0];
    bus.p2         = key_vis[1];
    bus.p3         = key_vis[2];
    bus.p4         = key_vis[3];
    bus.x_1        = key_vis[4];
    bus.x_2        = key_vis[5];
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: a frame-level model is compared every cycle,
// and hand-computed expectations pin the key scenarios.
module tb_key_loader;

  localparam int KEY_W    = 6;
  localparam int MAX_FAIL = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  key_loader_if bus ();

  key_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] dut_key;
  assign dut_key = {bus.x_2, bus.x_1, bus.p4, bus.p3, bus.p2, bus.p1};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collects accepted bits, judges a whole frame by parity,
  // then schedules the result (err one edge later, commit two edges later).
  typedef struct packed {
    logic [5:0] key;
    logic       loaded;
    logic       done;
    logic       err;
    logic       locked;
    logic       ready;
    int         fails;
    int         nbits;
    int         commit_in;
    int         err_in;
    logic [6:0] frame;
    logic [5:0] pend;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t cur, input logic sdi,
                                        input logic valid, input logic abort);
    model_t n = cur;
    n.done = 1'b0;
    n.err  = 1'b0;
    if (n.commit_in > 0) begin
      n.commit_in--;
      if (n.commit_in == 0) begin
        n.key = n.pend; n.loaded = 1'b1; n.done = 1'b1; n.fails = 0;
      end
    end
    if (n.err_in > 0) begin
      n.err_in--;
      if (n.err_in == 0) begin
        n.err = 1'b1;
        if (n.fails < MAX_FAIL) n.fails++;
        if (n.fails == MAX_FAIL) begin
          n.locked = 1'b1; n.key = '0; n.loaded = 1'b0;
        end
      end
    end
    if (cur.ready && abort) begin
      n.nbits = 0;
    end else if (cur.ready && valid) begin
      n.frame[n.nbits] = sdi;
      n.nbits++;
      if (n.nbits == KEY_W + 1) begin
        n.nbits = 0;
        if (^n.frame == 1'b0) begin
          n.commit_in = 2; n.pend = n.frame[5:0];
        end else begin
          n.err_in = 1;
        end
      end
    end
    n.ready = !n.locked && n.commit_in == 0 && n.err_in == 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, bus.sdi, bus.sdi_valid, bus.abort);
  end

  always @(posedge clk) begin
    #1;
    if (rst_n)
      check("cycle", {6'd0, bus.sdi_ready, dut_key, bus.key_loaded, bus.done, bus.err, bus.locked},
                     {6'd0, m.ready, m.key, m.loaded, m.done, m.err, m.locked});
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.sdi_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.sdi_ready) check("ready_timeout", 16'd0, 16'd1);
  endtask

  // Returns on the negedge that follows the last-bit transfer edge.
  task automatic send_frame(input logic [5:0] key, input logic par, input bit toggle);
    logic [6:0] f;
    f = {par, key};
    wait_ready();
    for (int i = 0; i < KEY_W + 1; i++) begin
      bus.sdi = f[i];
      bus.sdi_valid = 1'b1;
      @(negedge clk);
      if (toggle) begin
        bus.sdi_valid = 1'b0;
        bus.sdi = ~f[i];
        @(negedge clk);
      end
    end
    bus.sdi_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sdi = 1'b0;
    bus.sdi_valid = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {15'd0, bus.sdi_ready}, 16'd0);
    check("rst_key", {10'd0, dut_key}, 16'd0);
    check("rst_flags", {12'd0, bus.key_loaded, bus.done, bus.err, bus.locked}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {15'd0, bus.sdi_ready}, 16'd1);

    // Good frame 0x2D: done two edges after the last transfer.
    send_frame(6'h2D, 1'b0, 0);
    check("c31_done_e0", {15'd0, bus.done}, 16'd0);
    @(negedge clk);
    check("c31_done_e1", {15'd0, bus.done}, 16'd0);
    @(negedge clk);
    check("c31_done", {15'd0, bus.done}, 16'd1);
    check("c31_key", {10'd0, dut_key}, 16'h002D);
    check("c31_loaded", {15'd0, bus.key_loaded}, 16'd1);
    @(negedge clk);
    check("c31_done_clear", {14'd0, bus.done, bus.sdi_ready}, 16'd1);

    // Bad parity from reset: err one edge after the last transfer.
    do_reset();
    send_frame(6'h2D, 1'b1, 0);
    check("c32_busy", {14'd0, bus.sdi_ready, bus.err}, 16'd0);
    @(negedge clk);
    check("c32_err", {14'd0, bus.err, bus.sdi_ready}, 16'h0003);
    check("c32_key", {9'd0, dut_key, bus.key_loaded}, 16'd0);
    @(negedge clk);
    check("c32_err_clear", {15'd0, bus.err}, 16'd0);

    // Second and third bad frames reach MAX_FAIL and lock.
    send_frame(6'h2D, 1'b1, 0);
    @(negedge clk);
    check("c33_not_locked", {14'd0, bus.err, bus.locked}, 16'h0002);
    send_frame(6'h00, 1'b1, 0);
    @(negedge clk);
    check("c33_locked", {13'd0, bus.err, bus.locked, bus.sdi_ready}, 16'h0006);
    bus.sdi = 1'b1;
    bus.sdi_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.sdi_valid = 1'b0;
    check("c33_stay_locked", {8'd0, dut_key, bus.locked, bus.sdi_ready}, 16'h0002);
    do_reset();
    check("c33_unlocked", {14'd0, bus.locked, bus.sdi_ready}, 16'h0001);

    // Abort mid-frame keeps the committed key; the next frame replaces it.
    send_frame(6'h2D, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("c34_key_2d", {10'd0, dut_key}, 16'h002D);
    for (int i = 0; i < 3; i++) begin
      bus.sdi = 1'b0;
      bus.sdi_valid = 1'b1;
      @(negedge clk);
    end
    bus.abort = 1'b1;
    bus.sdi = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.sdi_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("c34_after_abort", {9'd0, dut_key, bus.key_loaded}, {9'd0, 6'h2D, 1'b1});
    send_frame(6'h12, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("c34_key_12", {10'd0, dut_key}, 16'h0012);

    // A commit clears the fail count; failed frames leave the key alone.
    send_frame(6'h01, 1'b0, 0);
    send_frame(6'h03, 1'b1, 0);
    send_frame(6'h2D, 1'b0, 0);
    send_frame(6'h07, 1'b0, 0);
    send_frame(6'h3F, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("fail_cleared", {9'd0, dut_key, bus.locked}, {9'd0, 6'h2D, 1'b0});

    // Gapped valid gives the same result as a back-to-back frame.
    send_frame(6'h35, 1'b0, 1);
    repeat (3) @(negedge clk);
    check("c35_key", {10'd0, dut_key}, 16'h0035);

    // Reset mid-frame discards it with no pulse; a fresh frame then commits.
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      bus.sdi = 1'b1;
      bus.sdi_valid = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    bus.sdi_valid = 1'b0;
    @(negedge clk);
    check("c36_cleared", {8'd0, dut_key, bus.key_loaded, bus.done, bus.err}, 16'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("c36_no_pulse", {14'd0, bus.done, bus.err}, 16'd0);
    send_frame(6'h2D, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("c36_key", {9'd0, dut_key, bus.key_loaded}, {9'd0, 6'h2D, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 6, number of key bits per frame; bit order p1,p2,p3,p4,x_1,x_2.
REQ-002 Parameter MAX_FAIL, default 3, number of parity-failed frames that forces LOCKED.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sdi  input  1  serial key/parity data bit.
REQ-006 sdi_valid  input  1  sdi carries a valid bit this cycle.
REQ-007 sdi_ready  output  1  loader accepts a bit this cycle.
REQ-008 abort  input  1  synchronous discard of the frame in progress.
REQ-009 p1, p2, p3, p4  output  1 each  committed key bits 0..3 to the locked combinational core.
REQ-010 x_1, x_2  output  1 each  committed key bits 4..5 to the core XOR key gates.
REQ-011 key_loaded  output  1  a valid key is committed.
REQ-012 done  output  1  one-cycle pulse on commit.
REQ-013 err  output  1  one-cycle pulse on parity failure.
REQ-014 locked  output  1  loader permanently locked until reset.

Function
REQ-015 Transfer SHALL occur only in a cycle with sdi_valid=1 and sdi_ready=1; otherwise no state changes from sdi.
REQ-016 Frame SHALL be KEY_W+1 transfers: KEY_W key bits LSB first (first bit -> p1), then one even-parity bit (XOR of all KEY_W+1 bits = 0 is valid).
REQ-017 States SHALL be IDLE, SHIFT, CHECK, COMMIT, LOCKED.
REQ-018 IDLE: sdi_ready=1; first transfer stores bit 0 into shadow register, bit counter=1, go SHIFT.
REQ-019 SHIFT: sdi_ready=1; each transfer stores next bit; on the (KEY_W+1)th transfer go CHECK.
REQ-020 CHECK (one cycle, sdi_ready=0): parity good -> COMMIT; parity bad -> increment fail counter, pulse err, go LOCKED if counter reaches MAX_FAIL else IDLE.
REQ-021 COMMIT (one cycle, sdi_ready=0): copy shadow to p1..x_2, set key_loaded=1, pulse done, clear fail counter, go IDLE.
REQ-022 done and err SHALL be asserted in the cycle after COMMIT/CHECK entry respectively is registered, i.e. visible exactly one cycle, 2 cycles after last-bit transfer for done, 1 cycle for err.
REQ-023 Committed outputs SHALL change only in COMMIT; a failed or aborted frame SHALL leave previous key and key_loaded unchanged.
REQ-024 abort=1 in IDLE or SHIFT SHALL clear bit counter and shadow and return to IDLE next cycle; abort has priority over a simultaneous transfer; abort ignored in CHECK, COMMIT, LOCKED.
REQ-025 LOCKED: sdi_ready=0, locked=1, p1..x_2 forced 0, key_loaded=0; exit only via rst_n.
REQ-026 A new frame after a commit SHALL overwrite the key only upon its own successful COMMIT.
REQ-027 Fail counter width SHALL be clog2(MAX_FAIL+1) and SHALL not wrap.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, shadow, bit counter, fail counter, p1..x_2, key_loaded, done, err, locked to 0, and sdi_ready to 0 while asserted.
REQ-029 After rst_n deasserts, sdi_ready SHALL be 1 from the first rising edge on.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no done or err pulse.

Verification
REQ-031 Frame bits 1,0,1,1,0,1 parity 0 -> done pulse 2 cycles after last transfer; p1..x_2=1,0,1,1,0,1; key_loaded=1.
REQ-032 Same key bits, parity 1 -> err pulse, outputs stay 0, key_loaded=0, sdi_ready=1 again after 1 cycle.
REQ-033 Three consecutive bad-parity frames (MAX_FAIL=3) -> locked=1, sdi_ready=0, further sdi_valid ignored; rst_n pulse -> all cleared.
REQ-034 Commit key 0x2D, then send 3 bits and abort -> key remains 0x2D; next full frame with key 0x12 parity 0 -> outputs become 0x12.
REQ-035 sdi_valid toggled 1/0 every cycle across a frame -> only valid cycles counted, result identical to back-to-back frame.
REQ-036 rst_n asserted after 4 transfers -> no pulses, outputs 0; fresh frame after release commits correctly.
